// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, FSM encodings and byte assembly helper for inst_fetch
package inst_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int BYTE_W      = 8;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;
    typedef logic [BYTE_W-1:0]      byte_t;

    // Fetch FSM encodings
    localparam logic [1:0] IF_IDLE = 2'd0;
    localparam logic [1:0] IF_RD   = 2'd1;
    localparam logic [1:0] IF_LAST = 2'd2;
    localparam logic [1:0] IF_HOLD = 2'd3;

    // Little-endian assembly: byte 0 is the lowest-addressed byte
    function automatic inst_t assemble(input byte_t b3, input byte_t b2,
                                       input byte_t b1, input byte_t b0);
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - byte-serial instruction fetch from shared RAM into a valid/ready slot
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        ce,
    input  logic        flush,
    output logic        stall_req,
    input  logic        mem_gnt,
    output logic        mem_re,
    output logic [31:0] mem_a,
    input  logic [7:0]  mem_din,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready
);

    logic [1:0] r_state;
    logic [1:0] r_cnt;
    byte_t      r_b [0:3];
    inst_t      r_inst;
    inst_addr_t r_inst_pc;
    logic       r_inst_valid;

    logic       w_start;
    logic       w_slot_free;
    logic       w_load_last;
    logic       w_load_hold;
    logic       w_complete;
    logic [1:0] w_idx;

    // A fetch may only begin from IDLE with the RAM granted; the grant is not
    // looked at again until the next fetch starts.
    assign w_start     = (r_state == IF_IDLE) && ce && !flush && mem_gnt;
    assign w_slot_free = !r_inst_valid || inst_ready;
    assign w_load_last = (r_state == IF_LAST) && w_slot_free && !flush;
    assign w_load_hold = (r_state == IF_HOLD) && w_slot_free && !flush;
    assign w_complete  = w_load_last || w_load_hold;
    assign w_idx       = r_cnt - 2'd1;

    // PC must hold until the slot is loaded; a flush releases it so the branch target loads
    assign stall_req = ce && !flush && !w_complete;

    // RAM request: start address from IDLE, then pc+1..pc+3 while gathering bytes
    always_comb begin
        mem_re = 1'b0;
        mem_a  = '0;
        case (r_state)
            IF_IDLE: begin
                if (w_start) begin
                    mem_re = 1'b1;
                    mem_a  = pc;
                end
            end
            IF_RD: begin
                if (!flush) begin
                    mem_re = 1'b1;
                    mem_a  = pc + {30'd0, r_cnt};
                end
            end
            default: begin
                mem_re = 1'b0;
                mem_a  = '0;
            end
        endcase
    end

    // Fetch FSM, byte buffer and output slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IF_IDLE;
            r_cnt        <= 2'd0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
        end else if (flush) begin
            r_state      <= IF_IDLE;
            r_cnt        <= 2'd0;
            r_inst_valid <= 1'b0;
        end else begin
            if (inst_ready) begin
                r_inst_valid <= 1'b0;
            end
            case (r_state)
                IF_IDLE: begin
                    if (w_start) begin
                        r_state <= IF_RD;
                        r_cnt   <= 2'd1;
                    end
                end
                IF_RD: begin
                    r_b[w_idx] <= mem_din;
                    if (r_cnt == 2'd3) begin
                        r_state <= IF_LAST;
                        r_cnt   <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                IF_LAST: begin
                    if (w_slot_free) begin
                        r_inst       <= assemble(mem_din, r_b[2], r_b[1], r_b[0]);
                        r_inst_pc    <= pc;
                        r_inst_valid <= 1'b1;
                        r_state      <= IF_IDLE;
                    end else begin
                        r_b[3]  <= mem_din;
                        r_state <= IF_HOLD;
                    end
                end
                default: begin
                    if (w_slot_free) begin
                        r_inst       <= assemble(r_b[3], r_b[2], r_b[1], r_b[0]);
                        r_inst_pc    <= pc;
                        r_inst_valid <= 1'b1;
                        r_state      <= IF_IDLE;
                    end
                end
            endcase
        end
    end

    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_inst_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        ce;
    logic        flush;
    logic        stall_req;
    logic        mem_gnt;
    logic        mem_re;
    logic [31:0] mem_a;
    logic [7:0]  mem_din;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    logic [7:0]  ram [0:255];
    int          n_checks;
    int          n_pass;

    inst_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .ce         (ce),
        .flush      (flush),
        .stall_req  (stall_req),
        .mem_gnt    (mem_gnt),
        .mem_re     (mem_re),
        .mem_a      (mem_a),
        .mem_din    (mem_din),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_din <= ram[mem_a[7:0]];
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ce = 1'b0; flush = 1'b0; mem_gnt = 1'b0; inst_ready = 1'b0; pc = '0;
        repeat (2) nxt();
        rst = 1'b0;
        #1;
        n_checks++; if (mem_re !== 1'b0) $display("FAIL reset_mem_re got %h want 0", mem_re); else n_pass++;
        n_checks++; if (mem_a !== 32'h0) $display("FAIL reset_mem_a got %h want 0", mem_a); else n_pass++;
        n_checks++; if (inst !== 32'h0) $display("FAIL reset_inst got %h want 0", inst); else n_pass++;
        n_checks++; if (inst_pc !== 32'h0) $display("FAIL reset_inst_pc got %h want 0", inst_pc); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid got %h want 0", inst_valid); else n_pass++;
        n_checks++; if (stall_req !== 1'b0) $display("FAIL reset_stall got %h want 0", stall_req); else n_pass++;
    endtask

    task automatic test_basic;
        pc = 32'h0; ce = 1'b1; mem_gnt = 1'b1; inst_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) ce = 1'b0;
            #1;
            if (c <= 3) begin
                n_checks++; if (mem_re !== 1'b1) $display("FAIL basic_mem_re c%0d got %h want 1", c, mem_re); else n_pass++;
                n_checks++; if (mem_a !== 32'(c)) $display("FAIL basic_mem_a c%0d got %h want %h", c, mem_a, 32'(c)); else n_pass++;
                n_checks++; if (stall_req !== 1'b1) $display("FAIL basic_stall c%0d got %h want 1", c, stall_req); else n_pass++;
            end
            if (c == 4) begin
                n_checks++; if (stall_req !== 1'b0) $display("FAIL basic_stall_t4 got %h want 0", stall_req); else n_pass++;
                n_checks++; if (mem_re !== 1'b0) $display("FAIL basic_mem_re_t4 got %h want 0", mem_re); else n_pass++;
                n_checks++; if (inst_valid !== 1'b0) $display("FAIL basic_valid_t4 got %h want 0", inst_valid); else n_pass++;
            end
            if (c == 5) begin
                n_checks++; if (inst_valid !== 1'b1) $display("FAIL basic_valid_t5 got %h want 1", inst_valid); else n_pass++;
                n_checks++; if (inst !== 32'h00100513) $display("FAIL basic_inst got %h want 00100513", inst); else n_pass++;
                n_checks++; if (inst_pc !== 32'h0) $display("FAIL basic_inst_pc got %h want 0", inst_pc); else n_pass++;
            end
            nxt();
        end
        #1;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL basic_valid_drop got %h want 0", inst_valid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_inst [0:2];
        int          n_valid;
        logic        adv;
        exp_inst[0] = 32'h00100513;
        exp_inst[1] = 32'h00200593;
        exp_inst[2] = 32'h00B58633;
        n_valid = 0;
        pc = 32'h0; ce = 1'b1; inst_ready = 1'b1; mem_gnt = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            adv = ce && !stall_req;
            if (inst_valid) begin
                n_valid++;
                n_checks++; if (c % 5 != 0 || c == 0) $display("FAIL b2b_valid_cycle got %0d want 5/10/15", c); else n_pass++;
                if (c >= 5 && c <= 15) begin
                    n_checks++; if (inst_pc !== 32'((c / 5 - 1) * 4)) $display("FAIL b2b_inst_pc c%0d got %h want %h", c, inst_pc, 32'((c / 5 - 1) * 4)); else n_pass++;
                    n_checks++; if (inst !== exp_inst[c / 5 - 1]) $display("FAIL b2b_inst c%0d got %h want %h", c, inst, exp_inst[c / 5 - 1]); else n_pass++;
                end
            end
            nxt();
            if (adv) pc = pc + 32'd4;
        end
        n_checks++; if (n_valid != 3) $display("FAIL b2b_count got %0d want 3", n_valid); else n_pass++;
        ce = 1'b0; flush = 1'b1;
        nxt();
        flush = 1'b0;
    endtask

    task automatic test_flush;
        int   n_valid;
        logic adv;
        n_valid = 0;
        pc = 32'h20; ce = 1'b1; inst_ready = 1'b1; mem_gnt = 1'b1;
        nxt();
        nxt();
        flush = 1'b1;
        #1;
        n_checks++; if (stall_req !== 1'b0) $display("FAIL flush_stall got %h want 0", stall_req); else n_pass++;
        n_checks++; if (mem_re !== 1'b0) $display("FAIL flush_mem_re got %h want 0", mem_re); else n_pass++;
        nxt();
        flush = 1'b0; pc = 32'h40;
        for (int c = 0; c < 7; c++) begin
            #1;
            if (c == 0) begin
                n_checks++; if (mem_re !== 1'b1) $display("FAIL flush_restart_re got %h want 1", mem_re); else n_pass++;
                n_checks++; if (mem_a !== 32'h40) $display("FAIL flush_restart_a got %h want 00000040", mem_a); else n_pass++;
                n_checks++; if (stall_req !== 1'b1) $display("FAIL flush_restart_stall got %h want 1", stall_req); else n_pass++;
            end
            if (inst_valid) begin
                n_valid++;
                n_checks++; if (c != 5) $display("FAIL flush_valid_cycle got %0d want 5", c); else n_pass++;
                n_checks++; if (inst_pc !== 32'h40) $display("FAIL flush_inst_pc got %h want 00000040", inst_pc); else n_pass++;
                n_checks++; if (inst !== 32'h0000006F) $display("FAIL flush_inst got %h want 0000006f", inst); else n_pass++;
            end
            adv = ce && !stall_req;
            nxt();
            if (adv) ce = 1'b0;
        end
        n_checks++; if (n_valid != 1) $display("FAIL flush_count got %0d want 1", n_valid); else n_pass++;
    endtask

    task automatic test_arbitration;
        pc = 32'h40; ce = 1'b1; mem_gnt = 1'b0; inst_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (stall_req !== 1'b1) $display("FAIL arb_stall c%0d got %h want 1", c, stall_req); else n_pass++;
            n_checks++; if (mem_re !== 1'b0) $display("FAIL arb_mem_re c%0d got %h want 0", c, mem_re); else n_pass++;
            nxt();
        end
        mem_gnt = 1'b1;
        #1;
        n_checks++; if (mem_re !== 1'b1) $display("FAIL arb_start_re got %h want 1", mem_re); else n_pass++;
        n_checks++; if (mem_a !== 32'h40) $display("FAIL arb_start_a got %h want 00000040", mem_a); else n_pass++;
        nxt();
        mem_gnt = 1'b0;
        for (int c = 1; c < 6; c++) begin
            #1;
            if (c <= 3) begin
                n_checks++; if (mem_re !== 1'b1 || mem_a !== 32'h40 + 32'(c)) $display("FAIL arb_rd c%0d got re=%h a=%h want re=1 a=%h", c, mem_re, mem_a, 32'h40 + 32'(c)); else n_pass++;
            end
            if (c == 4) begin
                n_checks++; if (stall_req !== 1'b0) $display("FAIL arb_stall_t4 got %h want 0", stall_req); else n_pass++;
            end
            if (c == 5) begin
                n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000006F) $display("FAIL arb_inst got v=%h i=%h want v=1 i=0000006f", inst_valid, inst); else n_pass++;
            end
            nxt();
            if (c == 4) ce = 1'b0;
        end
        mem_gnt = 1'b1;
    endtask

    task automatic test_backpressure_wrap;
        pc = 32'h40; ce = 1'b1; mem_gnt = 1'b1;
        for (int c = 0; c < 14; c++) begin
            inst_ready = (c >= 13);
            #1;
            if (c == 4) begin
                n_checks++; if (stall_req !== 1'b0) $display("FAIL bp_first_done got %h want 0", stall_req); else n_pass++;
            end
            if (c >= 5 && c <= 8) begin
                n_checks++; if (mem_re !== 1'b1 || mem_a !== 32'hFFFFFFFE + 32'(c - 5)) $display("FAIL wrap_mem_a c%0d got re=%h a=%h want re=1 a=%h", c, mem_re, mem_a, 32'hFFFFFFFE + 32'(c - 5)); else n_pass++;
            end
            if (c >= 9 && c <= 12) begin
                n_checks++; if (stall_req !== 1'b1) $display("FAIL bp_stall c%0d got %h want 1", c, stall_req); else n_pass++;
                n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000006F || inst_pc !== 32'h40) $display("FAIL bp_slot c%0d got v=%h i=%h pc=%h want v=1 i=0000006f pc=00000040", c, inst_valid, inst, inst_pc); else n_pass++;
            end
            if (c == 13) begin
                n_checks++; if (stall_req !== 1'b0) $display("FAIL bp_release got %h want 0", stall_req); else n_pass++;
            end
            nxt();
            if (c == 4) pc = 32'hFFFFFFFE;
            if (c == 13) ce = 1'b0;
        end
        #1;
        n_checks++; if (inst_valid !== 1'b1) $display("FAIL wrap_valid got %h want 1", inst_valid); else n_pass++;
        n_checks++; if (inst !== 32'h0513BBAA) $display("FAIL wrap_inst got %h want 0513bbaa", inst); else n_pass++;
        n_checks++; if (inst_pc !== 32'hFFFFFFFE) $display("FAIL wrap_inst_pc got %h want fffffffe", inst_pc); else n_pass++;
        nxt();
    endtask

    task automatic test_reset_mid;
        logic adv;
        pc = 32'h44; ce = 1'b1; mem_gnt = 1'b1; inst_ready = 1'b1;
        nxt();
        nxt();
        rst = 1'b1; ce = 1'b0;
        nxt();
        rst = 1'b0;
        #1;
        n_checks++; if (mem_re !== 1'b0 || mem_a !== 32'h0) $display("FAIL rstmid_mem got re=%h a=%h want 0", mem_re, mem_a); else n_pass++;
        n_checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) $display("FAIL rstmid_inst got i=%h pc=%h want 0", inst, inst_pc); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0 || stall_req !== 1'b0) $display("FAIL rstmid_flags got v=%h s=%h want 0", inst_valid, stall_req); else n_pass++;
        ce = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c < 5) begin
                n_checks++; if (inst_valid !== 1'b0) $display("FAIL rstmid_early_valid c%0d got %h want 0", c, inst_valid); else n_pass++;
            end else begin
                n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h000012B7 || inst_pc !== 32'h44) $display("FAIL rstmid_refetch got v=%h i=%h pc=%h want v=1 i=000012b7 pc=00000044", inst_valid, inst, inst_pc); else n_pass++;
            end
            adv = ce && !stall_req;
            nxt();
            if (adv) ce = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[0]  = 8'h13; ram[1]  = 8'h05; ram[2]  = 8'h10; ram[3]  = 8'h00;
        ram[4]  = 8'h93; ram[5]  = 8'h05; ram[6]  = 8'h20; ram[7]  = 8'h00;
        ram[8]  = 8'h33; ram[9]  = 8'h86; ram[10] = 8'hB5; ram[11] = 8'h00;
        ram[64] = 8'h6F; ram[65] = 8'h00; ram[66] = 8'h00; ram[67] = 8'h00;
        ram[68] = 8'hB7; ram[69] = 8'h12; ram[70] = 8'h00; ram[71] = 8'h00;
        ram[254] = 8'hAA; ram[255] = 8'hBB;
        mem_din = 8'h00;
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_arbitration();
        test_backpressure_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch responder for the RISC-V core: it consumes the fetch address and enable issued by the PC register and reads four bytes from the shared byte-wide RAM. It assembles them little-endian into a 32-bit instruction and hands it to the IF/ID stage over a valid/ready slot. While a fetch is incomplete it asserts `stall_req`, which feeds `stall[0]` so the PC holds. A branch `flush` aborts an in-progress fetch so the PC can load the target.

## Interface
- No parameters; widths come from the shared defines (`InstAddrBus` = 31:0, `InstBus` = 31:0).
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `pc`  in  32  fetch address from the PC register; stable while `stall_req` is high
- `ce`  in  1  fetch enable from the PC register; 0 during and just after reset
- `flush`  in  1  branch taken; abandon the current fetch
- `stall_req`  out  1  combinational; high = fetch of `pc` not finished, PC must hold
- `mem_gnt`  in  1  RAM port granted to fetch; sampled only when starting a fetch
- `mem_re`  out  1  RAM read enable
- `mem_a`  out  32  RAM byte address
- `mem_din`  in  8  RAM read data; valid one cycle after `mem_a`/`mem_re`
- `inst`  out  32  fetched instruction
- `inst_pc`  out  32  address of `inst`
- `inst_valid`  out  1  output slot holds an instruction
- `inst_ready`  in  1  IF/ID accepts the slot this cycle

## Operation
- States: IDLE, RD (byte counter `cnt` 1..3), LAST, HOLD. Byte buffer `b[0..2]`.
- IDLE, condition `ce && !flush && mem_gnt`:
  - Drive `mem_re`=1, `mem_a`=`pc`.
  - Go to RD with `cnt`=1.
  - If `ce && !mem_gnt`, stay in IDLE; `stall_req`=1.
- RD, step `cnt`=k:
  - Capture `mem_din` into `b[k-1]`.
  - Drive `mem_re`=1, `mem_a`=`pc`+k (32-bit add, wraps mod 2^32).
  - k<3: `cnt`++. k=3: go to LAST.
- LAST: byte 3 arrives on `mem_din`; `mem_re`=0.
  - If the slot is free (`!inst_valid || inst_ready`): load `inst`={`mem_din`,b2,b1,b0}, `inst_pc`=`pc`, `inst_valid`=1; drop `stall_req`; go to IDLE.
  - Otherwise capture byte 3 into `b[3]` and go to HOLD.
- HOLD: when the slot is free, load `inst` from `b[3..0]` with `inst_valid`=1, drop `stall_req`, go to IDLE.
- `inst_valid` clears on `inst_ready` when no new load happens in that cycle.
- `stall_req` = `ce && !flush && !complete`. `complete` is true only in the LAST/HOLD cycle that loads the slot.
- `flush` (any state):
  - Go to IDLE; `mem_re`=0; `inst_valid`<=0; `stall_req`=0, so the PC loads the branch target.
  - Bytes gathered so far are discarded.
  - `flush` has priority over completion and over `inst_ready`.
- Once started, a fetch owns the RAM until LAST. The data-side arbiter must not revoke it; `mem_gnt` is ignored after IDLE.

## Timing
- Reset values:
  - State IDLE, `cnt`=0.
  - `mem_re`=0, `mem_a`=0.
  - `inst`=0, `inst_pc`=0, `inst_valid`=0.
  - `stall_req`=0, which follows from `ce`=0.
- Fetch start at cycle T0 (IDLE, address `pc`):
  - Addresses `pc`+1..+3 at T1..T3.
  - Bytes 0..3 captured at T1..T4.
  - `inst_valid` high from T5.
  - `stall_req` high T0..T3, low at T4, so the PC advances at the end of T4.
- Throughput: one instruction per 5 cycles with no back-pressure.
- Back-pressure: every HOLD cycle adds one cycle; `stall_req` stays high throughout.
- Reset mid-fetch: return to IDLE immediately; no partial instruction is ever output.

## Structure
- Shared `defines.v` holds:
  - State encodings `IF_IDLE`, `IF_RD`, `IF_LAST`, `IF_HOLD`.
  - `InstAddrBus`, `InstBus`, `ByteBus`.
- Single module with no sub-module. The byte assembler is a 4-entry register and does not warrant its own block.

## Test plan
- Basic fetch: RAM[0..3]=13,05,10,00, `pc`=0, `ce`=1, `mem_gnt`=1, `inst_ready`=1.
  - `mem_a` steps 0,1,2,3 at T0..T3.
  - At T5: `inst`=0x00100513, `inst_pc`=0, `inst_valid`=1; `stall_req` low exactly at T4.
- Back-to-back: PC driven 0→4→8 per `stall_req`.
  - Three instructions appear at T5, T10, T15 with `inst_pc` 0, 4, 8.
- Flush: `flush` pulsed at RD `cnt`=2.
  - Same cycle: `stall_req`=0, `mem_re`=0.
  - Next cycle starts a fetch at the new `pc`; no instruction from the aborted address is ever valid.
- Arbitration: `mem_gnt`=0 for 3 cycles with `ce`=1.
  - State stays IDLE, `stall_req`=1, `mem_re`=0.
  - Fetch begins the cycle `mem_gnt` rises.
- Back-pressure and wrap:
  - `inst_ready`=0 for 4 cycles at completion: HOLD entered, slot unchanged, `stall_req` high; loads the cycle `inst_ready` returns.
  - `pc`=0xFFFFFFFE: `mem_a` sequence FFFFFFFE, FFFFFFFF, 0, 1.
- Reset mid-fetch: `rst` asserted at T2.
  - All outputs return to their reset values next cycle.
  - `inst_valid` stays 0 until a full new fetch completes.
